// File: rtl/spart_pkg.sv
// Shared definitions for the spart bus-side driver: register map, FSM states
// and the baud divisor helper.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    typedef enum logic [2:0] {
        RESET_CFG,
        CFG_LO,
        CFG_HI,
        IDLE,
        WRITE,
        TX_HOLD
    } drv_state_t;

    // sel 00..11 maps to 4800 * 2**sel baud; result is floor(clk/baud) - 1.
    function automatic logic [15:0] baud_div(input int unsigned clk_freq,
                                             input logic [1:0]  sel);
        int unsigned baud;
        int unsigned quot;
        baud = 32'd4800 << sel;
        quot = (clk_freq / baud) - 32'd1;
        return quot[15:0];
    endfunction

endpackage

// File: rtl/spart_driver_echo_fifo.sv
// Small synchronous FIFO holding received bytes until the transmitter can
// take them; pointers carry one extra wrap bit to tell full from empty.
module echo_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A push while full is refused even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// Bus master for the spart: programs the baud divisor from the board switches,
// then echoes every received byte back out through a small FIFO.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  logic [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    output logic       ovf,
    output logic [7:0] last_rx
);

    localparam logic [15:0] DIV_TAB [4] = '{
        baud_div(CLK_FREQ, 2'd0),
        baud_div(CLK_FREQ, 2'd1),
        baud_div(CLK_FREQ, 2'd2),
        baud_div(CLK_FREQ, 2'd3)
    };

    drv_state_t state;
    logic [1:0] cfg_meta;
    logic [1:0] cfg_sync;
    logic [1:0] cfg_prog;
    logic [1:0] cfg_pend;
    logic [7:0] data_q;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    assign databus = (iocs && !iorw) ? data_q : 'z;

    // iocs is only ever high during write cycles, so !iocs is the idle posture.
    assign push = rda && !iocs;
    assign pop  = (state == IDLE) && (cfg_sync == cfg_prog) &&
                  !fifo_empty && tbr && !rda;

    // Plain two-flop synchronizer; it keeps running through reset so the
    // switch setting is already settled when RESET_CFG is left.
    always_ff @(posedge clk) begin
        cfg_meta <= br_cfg;
        cfg_sync <= cfg_meta;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESET_CFG;
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= ADDR_DATA;
            data_q   <= '0;
            cfg_prog <= '0;
            cfg_pend <= '0;
            ovf      <= 1'b0;
            last_rx  <= '0;
        end else begin
            iocs   <= 1'b0;
            iorw   <= 1'b1;
            ioaddr <= ADDR_DATA;

            if (push) begin
                last_rx <= databus;
                if (fifo_full) begin
                    ovf <= 1'b1;
                end
            end

            // Bus outputs are registered for the state being entered.
            case (state)
                RESET_CFG: begin
                    state    <= CFG_LO;
                    cfg_pend <= cfg_sync;
                    iocs     <= 1'b1;
                    iorw     <= 1'b0;
                    ioaddr   <= ADDR_DBL;
                    data_q   <= DIV_TAB[cfg_sync][7:0];
                end
                CFG_LO: begin
                    state  <= CFG_HI;
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= ADDR_DBH;
                    data_q <= DIV_TAB[cfg_pend][15:8];
                end
                CFG_HI: begin
                    state    <= IDLE;
                    cfg_prog <= cfg_pend;
                end
                IDLE: begin
                    if (cfg_sync != cfg_prog) begin
                        state    <= CFG_LO;
                        cfg_pend <= cfg_sync;
                        iocs     <= 1'b1;
                        iorw     <= 1'b0;
                        ioaddr   <= ADDR_DBL;
                        data_q   <= DIV_TAB[cfg_sync][7:0];
                    end else if (pop) begin
                        state  <= WRITE;
                        iocs   <= 1'b1;
                        iorw   <= 1'b0;
                        ioaddr <= ADDR_DATA;
                        data_q <= fifo_dout;
                    end
                end
                WRITE: begin
                    state <= TX_HOLD;
                end
                TX_HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= RESET_CFG;
                end
            endcase
        end
    end

    echo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (databus),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: a schedule-of-bus-cycles model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0;
    logic       tbr = 1'b1;
    logic [7:0] tb_data = 8'h00;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       ovf;
    logic [7:0] last_rx;

    int checks = 0;
    int failures = 0;
    logic compare_en = 1'b0;

    // The bench plays the spart side: it drives the bus whenever the DUT does not.
    assign databus = (iocs && !iorw) ? 8'hzz : tb_data;

    spart_driver #(
        .CLK_FREQ   (50_000_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .ovf     (ovf),
        .last_rx (last_rx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cs;
        logic [1:0] addr;
        logic [7:0] data;
        logic       setp;
        logic [1:0] pcfg;
    } bus_t;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    bus_t       bus_now;
    bus_t       plan[$];
    logic [7:0] mfifo[$];
    logic       m_ovf;
    logic [7:0] m_last;
    logic       force_cfg;
    logic [1:0] prog;
    logic [1:0] h1 = 2'b00;
    logic [1:0] h2 = 2'b00;
    wr_t        wlog[$];

    function automatic logic [15:0] ref_div(input logic [1:0] sel);
        int unsigned baud;
        baud = 4800 * (1 << sel);
        return 16'(50_000_000 / baud - 1);
    endfunction

    function automatic bus_t mk(input logic cs, input logic [1:0] a,
                                input logic [7:0] d, input logic sp,
                                input logic [1:0] pc);
        bus_t b;
        b.cs = cs; b.addr = a; b.data = d; b.setp = sp; b.pcfg = pc;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Switch samples as seen two clock edges later.
    always @(posedge clk) begin
        h1 <= br_cfg;
        h2 <= h1;
    end

    always @(posedge clk or negedge rst) begin : model
        bus_t        nxt;
        logic [15:0] div;
        if (!rst) begin
            bus_now   = mk(1'b0, 2'b00, 8'h00, 1'b0, 2'b00);
            plan.delete();
            mfifo.delete();
            m_ovf     = 1'b0;
            m_last    = 8'h00;
            force_cfg = 1'b1;
            prog      = 2'b00;
        end else begin
            if (plan.size() > 0) begin
                nxt = plan.pop_front();
                if (nxt.setp) prog = nxt.pcfg;
            end else if (force_cfg || h2 != prog) begin
                div = ref_div(h2);
                nxt = mk(1'b1, 2'b10, div[7:0], 1'b0, 2'b00);
                plan.push_back(mk(1'b1, 2'b11, div[15:8], 1'b0, 2'b00));
                plan.push_back(mk(1'b0, 2'b00, 8'h00, 1'b1, h2));
                force_cfg = 1'b0;
            end else if (mfifo.size() > 0 && tbr && !rda) begin
                nxt = mk(1'b1, 2'b00, mfifo.pop_front(), 1'b0, 2'b00);
                plan.push_back(mk(1'b0, 2'b00, 8'h00, 1'b0, 2'b00));
                plan.push_back(mk(1'b0, 2'b00, 8'h00, 1'b0, 2'b00));
            end else begin
                nxt = mk(1'b0, 2'b00, 8'h00, 1'b0, 2'b00);
            end
            if (rda && !bus_now.cs) begin
                m_last = tb_data;
                if (mfifo.size() >= 4) m_ovf = 1'b1;
                else mfifo.push_back(tb_data);
            end
            bus_now = nxt;
        end
    end

    always @(negedge clk) begin
        logic [11:0] act;
        logic [11:0] exp;
        if (compare_en) begin
            act = {iocs, iorw, ioaddr, (iocs && !iorw) ? databus : 8'h00};
            exp = {bus_now.cs, !bus_now.cs, bus_now.addr,
                   bus_now.cs ? bus_now.data : 8'h00};
            check("bus", 32'(act), 32'(exp));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("last_rx", 32'(last_rx), 32'(m_last));
            if (rst && iocs && !iorw) wlog.push_back({ioaddr, databus});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rda = 1'b1;
        tb_data = b;
        tick(1);
        rda = 1'b0;
        tick(1);
    endtask

    task automatic check_log(input string name, input int idx,
                             input logic [1:0] a, input logic [7:0] d);
        if (idx < wlog.size()) check(name, 32'(wlog[idx]), 32'({a, d}));
        else check(name, 32'hFFFF_FFFF, 32'({a, d}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with 9600 baud selected
        tick(4);
        compare_en = 1'b1;
        check("reset_bus", 32'({iocs, iorw, ioaddr}), 32'({1'b0, 1'b1, 2'b00}));
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_last_rx", 32'(last_rx), 32'h00);
        wlog.delete();
        rst = 1'b1;
        tick(6);
        check("cfg_count", wlog.size(), 2);
        check_log("cfg_lo_9600", 0, 2'b10, 8'h57);
        check_log("cfg_hi_9600", 1, 2'b11, 8'h14);
        check("cfg_ovf", 32'(ovf), 32'd0);

        // Single echo
        wlog.delete();
        send(8'hA5);
        tick(3);
        check("echo_last_rx", 32'(last_rx), 32'hA5);
        check("echo_count", wlog.size(), 1);
        check_log("echo_data", 0, 2'b00, 8'hA5);

        // Overflow with transmitter blocked
        tbr = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i));
        check("ovf_set", 32'(ovf), 32'd1);
        wlog.delete();
        tbr = 1'b1;
        tick(16);
        check("ovf_drain_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) check_log("ovf_drain_data", i, 2'b00, 8'(i + 1));
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Reconfigure to 38400 with two bytes pending
        wlog.delete();
        tbr = 1'b0;
        send(8'h3C);
        send(8'hC3);
        br_cfg = 2'b11;
        tick(4);
        tbr = 1'b1;
        tick(16);
        check("recfg_count", wlog.size(), 4);
        check_log("recfg_lo", 0, 2'b10, 8'h15);
        check_log("recfg_hi", 1, 2'b11, 8'h05);
        check_log("recfg_echo0", 2, 2'b00, 8'h3C);
        check_log("recfg_echo1", 3, 2'b00, 8'hC3);

        // rda collides with a pending write
        wlog.delete();
        tbr = 1'b0;
        send(8'h11);
        tbr = 1'b1;
        rda = 1'b1;
        tb_data = 8'h22;
        tick(1);
        rda = 1'b0;
        tick(10);
        check("slip_count", wlog.size(), 2);
        check_log("slip_first", 0, 2'b00, 8'h11);
        check_log("slip_second", 1, 2'b00, 8'h22);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            if (rda) rda = 1'b0;
            else rda = ($urandom_range(0, 3) == 0);
            tb_data = 8'($urandom);
            tbr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) br_cfg = 2'($urandom);
            tick(1);
        end

        // Reset in the middle of a write
        rda = 1'b0;
        tbr = 1'b0;
        br_cfg = 2'b11;
        tick(10);
        send(8'h77);
        send(8'h88);
        tick(2);
        tbr = 1'b1;
        tick(1);
        check("pre_reset_write", 32'({iocs, iorw}), 32'({1'b1, 1'b0}));
        rst = 1'b0;
        #1;
        check("async_reset_bus", 32'({iocs, iorw, ioaddr}), 32'({1'b1 ^ 1'b1, 1'b1, 2'b00}));
        check("async_reset_ovf_rx", 32'({ovf, last_rx}), 32'h000);
        tick(2);
        wlog.delete();
        rst = 1'b1;
        tick(12);
        check("rst_recfg_count", wlog.size(), 2);
        check_log("rst_recfg_lo", 0, 2'b10, 8'h15);
        check_log("rst_recfg_hi", 1, 2'b11, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
